// File: rtl/pattern_recorder.sv
// pattern_recorder: quantizes live {note,octave} bytes to tracker rows on the
// song tick and writes one byte per row into the bar RAM.
// Latency: a row's write appears 1 cycle after its row-ending tick. done pulses
// 1 cycle after the final write.
// Backpressure: note_ready is high whenever recording (SYNC/RECORD). There is
// no stall; the RAM write port is assumed always ready.
// Ports: main_clk/rst_n clock and async active-low reset.
//   tick/arm/abort: strobes. bar_sel/num_bars: recording setup, sampled on arm.
//   note_valid/note_in/note_ready: note handshake.
//   wr_en/wr_addr/wr_data: bar RAM write port.
//   busy/done/row_pos/bar_pos: status.
module pattern_recorder #(
  parameter int TICKS_PER_ROW = 8,
  parameter int BAR_BITS      = 3
) (
  input  logic                  main_clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [BAR_BITS-1:0]   bar_sel,
  input  logic [BAR_BITS:0]     num_bars,
  input  logic                  note_valid,
  input  logic [7:0]            note_in,
  output logic                  note_ready,
  output logic                  wr_en,
  output logic [BAR_BITS+3:0]   wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            row_pos,
  output logic [BAR_BITS-1:0]   bar_pos
);

  localparam int CW = $clog2(TICKS_PER_ROW);
  localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_ROW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_REC} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            row_q, row_d;
  logic [BAR_BITS-1:0]   bar_q, bar_d;
  logic [BAR_BITS:0]     left_q, left_d;
  logic [7:0]            pend_q, pend_d;
  logic                  fin_q, fin_d;
  logic                  wr_en_q, wr_en_d;
  logic [BAR_BITS+3:0]   wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  note_ok;
  logic [7:0]            pend_nxt;

  // Only well-formed notes (C..B, octave 0..6) reach the pending byte.
  assign note_ok  = note_valid && (state_q != S_IDLE) &&
                    (note_in[7:4] >= 4'd1) && (note_in[7:4] <= 4'd12) &&
                    (note_in[3:0] <= 4'd6);
  assign pend_nxt = note_ok ? note_in : pend_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    bar_d     = bar_q;
    left_d    = left_q;
    pend_d    = pend_q;
    fin_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_SYNC;
          bar_d   = bar_sel;
          row_d   = 4'd0;
          cnt_d   = '0;
          pend_d  = 8'h00;
          left_d  = (num_bars == '0) ? (BAR_BITS+1)'(1) : num_bars;
        end
      end
      S_SYNC: begin
        pend_d = pend_nxt;
        if (abort) begin
          state_d = S_IDLE;
        end else if (tick) begin
          // The sync tick is tick 0 of row 0.
          state_d = S_REC;
          cnt_d   = CW'(1);
        end
      end
      S_REC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fin_q) begin
          // Final write is on the port this cycle; finish next cycle.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          pend_d = pend_nxt;
          if (tick) begin
            if (cnt_q != LAST_TICK) begin
              cnt_d = cnt_q + CW'(1);
            end else begin
              // Row ends: a note arriving with this tick still belongs here.
              wr_en_d   = 1'b1;
              wr_addr_d = {bar_q, row_q};
              wr_data_d = pend_nxt;
              pend_d    = 8'h00;
              cnt_d     = '0;
              row_d     = row_q + 4'd1;
              if (row_q == 4'd15) begin
                bar_d  = bar_q + BAR_BITS'(1);
                left_d = left_q - (BAR_BITS+1)'(1);
                if (left_q == (BAR_BITS+1)'(1)) fin_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_q     <= 4'd0;
      bar_q     <= '0;
      left_q    <= '0;
      pend_q    <= 8'h00;
      fin_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      bar_q     <= bar_d;
      left_q    <= left_d;
      pend_q    <= pend_d;
      fin_q     <= fin_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign note_ready = (state_q != S_IDLE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign row_pos    = row_q;
  assign bar_pos    = bar_q;

endmodule

// File: doc/pattern_recorder.md
# pattern_recorder

Live note-capture block: the reverse of the tracker playback path. It accepts note bytes from a live source (keyboard scanner, UART/MIDI front end), quantizes them to tracker rows on the song tick, and writes one byte per row into the bar RAM. The bytes use the same `{note[3:0], octave[3:0]}` format the song player consumes. It sits between the input front end and the write port of the bar memory, in the `main_clk` domain.

## Interface
- `TICKS_PER_ROW`, 8: ticks per tracker row; legal range 2..256.
- `BAR_BITS`, 3: bar index width; 2^BAR_BITS bars of 16 rows each.

Ports:
- `main_clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle song-tick strobe.
- `arm` in 1: one-cycle start-recording strobe.
- `abort` in 1: one-cycle stop strobe.
- `bar_sel` in BAR_BITS: first bar to record; sampled on accepted `arm`.
- `num_bars` in BAR_BITS+1: number of bars to record; sampled on accepted `arm`; 0 is treated as 1.
- `note_valid` in 1: `note_in` is valid.
- `note_in` in 8: `{note, octave}`; note 1..12 = C..B, octave 0..6.
- `note_ready` out 1: a note is accepted when `note_valid && note_ready`.
- `wr_en` out 1: bar RAM write strobe.
- `wr_addr` out BAR_BITS+4: `{bar, row}`.
- `wr_data` out 8: row byte; `8'h00` = rest.
- `busy` out 1: high in SYNC or RECORD.
- `done` out 1: one-cycle pulse when recording completes.
- `row_pos` out 4: current row.
- `bar_pos` out BAR_BITS: current bar.

## Operation
- **States:**
  - IDLE: `arm` → SYNC.
  - SYNC: `tick` → RECORD.
  - RECORD: last row of last bar ends → IDLE, with `done`.
  - `abort` in SYNC or RECORD → IDLE.
- **On accepted `arm` (IDLE only):**
  - `bar_pos` = `bar_sel`, `row_pos` = 0, `tick_cnt` = 0, pending byte = 00.
  - `bars_left` = max(`num_bars`, 1).
  - `arm` while busy is ignored.
- **SYNC:**
  - Notes are accepted as count-in; they land in row 0.
  - The first `tick` is tick 0 of row 0, so `tick_cnt` becomes 1.
- **RECORD, on each `tick`:**
  - If `tick_cnt` < TICKS_PER_ROW-1: increment `tick_cnt`.
  - Otherwise the row ends:
    - next cycle `wr_en`=1, `wr_addr`={`bar_pos`,`row_pos`}, `wr_data`=pending;
    - pending clears, `tick_cnt`=0;
    - `row_pos` increments;
    - when `row_pos` wraps 15→0: `bar_pos` increments modulo 2^BAR_BITS and `bars_left` decrements.
- **Note validity:**
  - Valid: note 1..12 and octave 0..6.
  - Valid accepted notes overwrite pending; the last note in a row wins.
  - Invalid notes are accepted (handshake completes) and discarded; pending is unchanged.
- **Simultaneous events:**
  - Note accepted in the same cycle as a row-ending tick belongs to the ending row and is written.
  - `abort` has priority over a tick and over the final write in the same cycle.
  - `abort` in IDLE is ignored.
- **Completion:** the write of row 15 with `bars_left`==1 is the final write. `done` pulses the following cycle, and the state is IDLE in that same cycle.
- **`note_ready`** = state != IDLE (combinational from state).

## Timing
- **Reset values:** state IDLE; all outputs 0, including `note_ready`, `wr_en`, `done`, `busy`, `row_pos`, `bar_pos`, `wr_addr`, `wr_data`.
- **Reset mid-recording:** returns to IDLE immediately with no further writes.
- **Registered outputs:**
  - `wr_en`, `wr_addr`, `wr_data`, `done`, `busy` are registered.
  - Write latency is 1 cycle after the row-ending tick.
  - `wr_en` is high for exactly 1 cycle per row.
- **`busy`** rises the cycle after `arm` and falls in the same cycle `done` is high.
- **After `abort`:** IDLE on the next cycle; no `wr_en` and no `done` thereafter; rows already written stay written.
- **`tick` during IDLE** has no effect.
- **Throughput:** one write per TICKS_PER_ROW ticks; exactly 16×`bars_left` writes per completed recording.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → all outputs 0; release → IDLE, `note_ready`=0.
- **Single bar:** `bar_sel`=2, `num_bars`=1, tick every 4 clocks, note 0x54 during row 2 → 16 writes at addr 0x20..0x2F spaced 32 clocks; addr 0x22 = 0x54, all others 0x00; `done` 1 cycle after the addr 0x2F write.
- **Last-wins, boundary and invalid:**
  - 0x13 then 0xA5 in row 0 → row 0 = 0xA5.
  - 0x66 in the cycle of row 3's final tick → row 3 = 0x66.
  - 0xD4 or 0x17 alone in a row → that row = 0x00.
- **Bar wrap:** `bar_sel`=7, `num_bars`=2 → 32 writes, addr 0x70..0x7F then 0x00..0x0F.
- **`num_bars`=0** → 16 writes; also `arm` pulsed mid-recording → ignored, no restart.
- **Abort:**
  - `abort` during row 5 → no further `wr_en`, no `done`, `busy`=0 next cycle.
  - `abort` coincident with the final row-end tick → that write suppressed.
  - A fresh `arm` afterwards records normally.
